imem_boot_loader: RTL

Upstream boot stage for `single_cycle_mips`. Receives a program image as a byte stream over a valid/ready handshake, writes it word-by-word into the instruction memory write port, and holds the CPU in reset until the image is fully and correctly loaded. Replaces the bench-only `$readmemh` preload so the same image can be delivered in silicon or by a serial front end.

---
 rtl/imem_boot_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// ============================================================================
// imem_boot_loader
// ----------------------------------------------------------------------------
// Boot stage that sits in front of single_cycle_mips. It receives a program
// image as a byte stream over a valid/ready handshake and writes it one word at
// a time into the instruction-memory write port. The CPU is held in reset
// until the whole image has landed in imem.
//
// Stream layout:
//    length N  : 2 bytes, big-endian (16-bit unsigned word count)
//    data      : N x 4 bytes, each word big-endian (first byte -> bits 31:24)
//    checksum  : 1 byte, XOR of all data bytes (only with the macro below)
//
// Build option:
//    IMEM_LOADER_CHECKSUM_EN - when defined, adds the CHK state and the XOR
//    accumulator. A checksum byte follows the data, and a mismatch sends the
//    loader to ERR. When undefined, the loader goes from the last data byte
//    (or from an empty length) straight to RUN.
//
// Ports:
//    clk         in   rising-edge clock
//    reset       in   synchronous, active-high reset
//    rx_valid    in   a byte is present on rx_data
//    rx_data     in   [7:0] stream byte
//    rx_ready    out  loader can accept a byte (registered, depends on state)
//    mem_we      out  one-cycle imem write strobe
//    mem_addr    out  [ADDR_W-1:0] word address of the write
//    mem_wdata   out  [31:0] assembled instruction word
//    cpu_reset   out  CPU reset, held high until the load completes
//    done        out  image loaded and CPU released
//    error       out  sticky load failure (cleared only by reset)
//    word_count  out  [ADDR_W:0] number of words written so far
// ============================================================================
module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CHK, RUN, ERR} state_t;
`else
   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, RUN, ERR} state_t;
`endif

   localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic [7:0]        len_hi;
   logic [ADDR_W:0]   len_words;
   logic [1:0]        byte_cnt;
   logic [23:0]       shift_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_acc;
`endif

   logic              accept;
   logic [15:0]       len_full;
   logic              len_too_big;
   logic              last_word;

   // A byte moves only on an edge where both sides of the handshake agree.
   // The oversize test is done on the full 16-bit length so that large
   // lengths cannot alias down to small legal ones. Once the length has
   // passed that test it fits in ADDR_W+1 bits, which is all the word
   // counter needs.
   assign accept      = rx_valid && rx_ready;
   assign len_full    = {len_hi, rx_data};
   assign len_too_big = {1'b0, len_full} > 17'(MAX_WORDS);
   assign last_word   = (word_count + ONE_WORD) == len_words;

   // Loader FSM with all outputs registered.
   // rx_ready defaults to 1 and is cleared on any transition into RUN or ERR,
   // so it drops in the same cycle the stream closes and no extra byte is
   // taken. Release is one edge after RUN is entered, which lets the final
   // mem_we commit to imem before the CPU's first fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LEN_HI;
         rx_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         len_hi     <= '0;
         len_words  <= '0;
         byte_cnt   <= '0;
         shift_word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_acc    <= '0;
`endif
      end else begin
         mem_we   <= 1'b0;
         rx_ready <= 1'b1;
         case (state)
            LEN_HI: begin
               if (accept) begin
                  len_hi <= rx_data;
                  state  <= LEN_LO;
               end
            end

            LEN_LO: begin
               if (accept) begin
                  len_words <= len_full[ADDR_W:0];
                  if (len_too_big) begin
                     state    <= ERR;
                     error    <= 1'b1;
                     rx_ready <= 1'b0;
                  end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state    <= CHK;
`else
                     state    <= RUN;
                     rx_ready <= 1'b0;
`endif
                  end else begin
                     state <= DATA;
                  end
               end
            end

            // byte_cnt wraps from 3 back to 0, so it realigns itself for
            // the next word without an explicit clear.
            DATA: begin
               if (accept) begin
                  shift_word <= {shift_word[15:0], rx_data};
                  byte_cnt   <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_acc    <= xor_acc ^ rx_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     mem_we     <= 1'b1;
                     mem_addr   <= word_count[ADDR_W-1:0];
                     mem_wdata  <= {shift_word, rx_data};
                     word_count <= word_count + ONE_WORD;
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHK;
`else
                        state    <= RUN;
                        rx_ready <= 1'b0;
`endif
                     end
                  end
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  if (rx_data == xor_acc) begin
                     state <= RUN;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            RUN: begin
               rx_ready  <= 1'b0;
               cpu_reset <= 1'b0;
               done      <= 1'b1;
            end

            ERR: begin
               rx_ready  <= 1'b0;
               cpu_reset <= 1'b1;
               error     <= 1'b1;
            end

            default: begin
               state    <= ERR;
               error    <= 1'b1;
               rx_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
